// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source producing pixel coordinates, the
// active-video flag, hsync/vsync and a one-cycle next_frame strobe.
// Flags are derived from the next counter values and registered together
// with x/y, so every output describes the same pixel in the same cycle.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       next_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 10 bits wide, so a line or frame longer than 1024 cannot be
  // represented; refuse such a configuration at elaboration.
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end

  // Last count values of a line / frame.
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Region boundaries kept at 11 bits: a sync pulse may end exactly at 1024.
  localparam logic [10:0] H_ACT_E  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_S = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_E  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_S = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_E = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       next_frame_q, next_frame_d;

  logic [10:0] x_ext_s;
  logic [10:0] y_ext_s;

  assign x_ext_s = {1'b0, x_d};
  assign y_ext_s = {1'b0, y_d};

  // Next-state: advance the raster position and derive flags for it; hold all when en is low.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    active_d     = active_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    next_frame_d = next_frame_q;
    if (en) begin
      if (x_q == H_LAST) begin
        x_d = 10'd0;
        if (y_q == V_LAST) begin
          y_d = 10'd0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
        y_d = y_q;
      end
      active_d     = (x_ext_s < H_ACT_E) && (y_ext_s < V_ACT_E);
      hsync_d      = ((x_ext_s >= H_SYNC_S) && (x_ext_s < H_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
      vsync_d      = ((y_ext_s >= V_SYNC_S) && (y_ext_s < V_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
      next_frame_d = (x_d == 10'd0) && (y_ext_s == V_ACT_E);
    end else begin
      x_d          = x_q;
      y_d          = y_q;
      active_d     = active_q;
      hsync_d      = hsync_q;
      vsync_d      = vsync_q;
      next_frame_d = next_frame_q;
    end
  end

  // State registers with synchronous active-low reset to the top-left, syncs deasserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      active_q     <= 1'b0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      next_frame_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      active_q     <= active_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      next_frame_q <= next_frame_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign active     = active_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign next_frame = next_frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen using three instances:
// default 640x480 timing (reset, line timing), a medium raster for whole-frame
// behaviour and en freezing, and a tiny raster for mid-frame reset and wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Expected {active, hsync, vsync, next_frame} for a position, active-low syncs.
  function automatic logic [3:0] exp_flags(input int px, input int py,
                                           input int ha, input int hfp, input int hsw,
                                           input int va, input int vfp, input int vsw);
    logic a, h, v, n;
    a = (px < ha) && (py < va);
    h = !((px >= ha + hfp) && (px < ha + hfp + hsw));
    v = !((py >= va + vfp) && (py < va + vfp + vsw));
    n = (px == 0) && (py == va);
    return {a, h, v, n};
  endfunction

  // Default instance
  logic       d_rst_n, d_en, d_act, d_hs, d_vs, d_nf;
  logic [9:0] d_x, d_y;
  vga_timing_gen u_dflt (
    .clk(clk), .rst_n(d_rst_n), .en(d_en), .x(d_x), .y(d_y),
    .active(d_act), .hsync(d_hs), .vsync(d_vs), .next_frame(d_nf)
  );

  // Medium instance: H 64/4/8/4 (80), V 48/2/2/4 (56)
  logic       m_rst_n, m_en, m_act, m_hs, m_vs, m_nf;
  logic [9:0] m_x, m_y;
  vga_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b0)
  ) u_med (
    .clk(clk), .rst_n(m_rst_n), .en(m_en), .x(m_x), .y(m_y),
    .active(m_act), .hsync(m_hs), .vsync(m_vs), .next_frame(m_nf)
  );

  // Small instance: H 4/1/2/1 (8), V 3/1/1/1 (6)
  logic       s_rst_n, s_en, s_act, s_hs, s_vs, s_nf;
  logic [9:0] s_x, s_y;
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .rst_n(s_rst_n), .en(s_en), .x(s_x), .y(s_y),
    .active(s_act), .hsync(s_hs), .vsync(s_vs), .next_frame(s_nf)
  );

  initial begin
    int mism, act_cnt, hs_cnt, hs_first, last_zero, period;
    int nf_cnt, nf_bad, f0, f1, vs_cnt, vs_x, vs_y, nf_step, nf_x, nf_y;
    int found;
    logic [3:0] ef;

    d_rst_n = 1'b0; d_en = 1'b1;
    m_rst_n = 1'b0; m_en = 1'b1;
    s_rst_n = 1'b0; s_en = 1'b1;

    // 1. Reset held for 5 cycles with en high
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("rst_x", 32'(d_x), 32'd0);
      check_val("rst_y", 32'(d_y), 32'd0);
      check_val("rst_active", 32'(d_act), 32'd0);
      check_val("rst_hsync", 32'(d_hs), 32'd1);
      check_val("rst_vsync", 32'(d_vs), 32'd1);
      check_val("rst_next_frame", 32'(d_nf), 32'd0);
    end

    // 2. Default timing: two lines plus a bit
    d_rst_n = 1'b1;
    mism = 0; act_cnt = 0; hs_cnt = 0; hs_first = -1; last_zero = -1; period = 0;
    for (int s = 1; s <= 1700; s++) begin
      @(negedge clk);
      ef = exp_flags(s % 800, s / 800, 640, 16, 96, 480, 10, 2);
      if ((int'(d_x) != s % 800) || (int'(d_y) != s / 800) ||
          ({d_act, d_hs, d_vs, d_nf} !== ef)) mism++;
      if (d_y == 10'd1) begin
        if (d_act) act_cnt++;
        if (!d_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(d_x);
        end
      end
      if (d_x == 10'd0) begin
        if (last_zero >= 0) period = s - last_zero;
        last_zero = s;
      end
    end
    check_val("d_align", 32'(mism), 32'd0);
    check_val("d_active_per_line", 32'(act_cnt), 32'd640);
    check_val("d_hsync_width", 32'(hs_cnt), 32'd96);
    check_val("d_hsync_start", 32'(hs_first), 32'd656);
    check_val("d_line_period", 32'(period), 32'd800);
    check_val("d_x_end", 32'(d_x), 32'd100);
    check_val("d_y_end", 32'(d_y), 32'd2);
    d_rst_n = 1'b0;

    // 3/4. Medium raster: three frames
    m_rst_n = 1'b1;
    mism = 0; nf_cnt = 0; nf_bad = 0; f0 = -1; f1 = -1;
    vs_cnt = 0; vs_x = -1; vs_y = -1; act_cnt = 0;
    for (int s = 1; s <= 13450; s++) begin
      @(negedge clk);
      ef = exp_flags(s % 80, (s / 80) % 56, 64, 4, 8, 48, 2, 2);
      if ((int'(m_x) != s % 80) || (int'(m_y) != (s / 80) % 56) ||
          ({m_act, m_hs, m_vs, m_nf} !== ef)) mism++;
      if (m_nf) begin
        nf_cnt++;
        if (!((m_x == 10'd0) && (m_y == 10'd48))) nf_bad++;
      end
      if ((m_x == 10'd0) && (m_y == 10'd0)) begin
        if (f0 < 0) f0 = s;
        else if (f1 < 0) f1 = s;
      end
      if ((s >= 4480) && (s < 8960)) begin
        if (m_act) act_cnt++;
        if (!m_vs) begin
          vs_cnt++;
          if (vs_x < 0) begin
            vs_x = int'(m_x);
            vs_y = int'(m_y);
          end
        end
      end
    end
    check_val("m_align", 32'(mism), 32'd0);
    check_val("m_frame_period", 32'(f1 - f0), 32'd4480);
    check_val("m_vsync_width", 32'(vs_cnt), 32'd160);
    check_val("m_vsync_start_x", 32'(vs_x), 32'd0);
    check_val("m_vsync_start_y", 32'(vs_y), 32'd50);
    check_val("m_active_per_frame", 32'(act_cnt), 32'd3072);
    check_val("m_next_frame_pulses", 32'(nf_cnt), 32'd3);
    check_val("m_next_frame_pos", 32'(nf_bad), 32'd0);

    // 5. Freeze with en low at the last visible pixel
    found = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ((m_x == 10'd63) && (m_y == 10'd47)) begin
        found = 1;
        break;
      end
    end
    check_val("m_reach_63_47", 32'(found), 32'd1);
    m_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_val("m_freeze_x", 32'(m_x), 32'd63);
      check_val("m_freeze_y", 32'(m_y), 32'd47);
      check_val("m_freeze_active", 32'(m_act), 32'd1);
    end
    m_en = 1'b1;
    @(negedge clk);
    check_val("m_resume_x", 32'(m_x), 32'd64);
    check_val("m_resume_y", 32'(m_y), 32'd47);
    check_val("m_resume_active", 32'(m_act), 32'd0);
    m_rst_n = 1'b0;

    // 6. Small raster: reset at (5,4) inside both sync pulses
    s_rst_n = 1'b1;
    for (int s = 1; s <= 37; s++) @(negedge clk);
    check_val("s_pre_x", 32'(s_x), 32'd5);
    check_val("s_pre_y", 32'(s_y), 32'd4);
    check_val("s_pre_hsync", 32'(s_hs), 32'd0);
    check_val("s_pre_vsync", 32'(s_vs), 32'd0);
    s_rst_n = 1'b0;
    @(negedge clk);
    check_val("s_rst_x", 32'(s_x), 32'd0);
    check_val("s_rst_y", 32'(s_y), 32'd0);
    check_val("s_rst_active", 32'(s_act), 32'd0);
    check_val("s_rst_hsync", 32'(s_hs), 32'd1);
    check_val("s_rst_vsync", 32'(s_vs), 32'd1);
    check_val("s_rst_next_frame", 32'(s_nf), 32'd0);
    s_rst_n = 1'b1;
    nf_cnt = 0; nf_step = -1; nf_x = -1; nf_y = -1;
    for (int s = 1; s <= 48; s++) begin
      @(negedge clk);
      if (s_nf) begin
        nf_cnt++;
        nf_step = s;
        nf_x = int'(s_x);
        nf_y = int'(s_y);
      end
      if (s == 47) begin
        check_val("s_last_x", 32'(s_x), 32'd7);
        check_val("s_last_y", 32'(s_y), 32'd5);
      end
      if (s == 48) begin
        check_val("s_wrap_x", 32'(s_x), 32'd0);
        check_val("s_wrap_y", 32'(s_y), 32'd0);
        check_val("s_wrap_active", 32'(s_act), 32'd1);
      end
    end
    check_val("s_next_frame_count", 32'(nf_cnt), 32'd1);
    check_val("s_next_frame_step", 32'(nf_step), 32'd24);
    check_val("s_next_frame_x", 32'(nf_x), 32'd0);
    check_val("s_next_frame_y", 32'(nf_y), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
